uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning bclk_in ticks per serial bit; legal value 16 only.
REQ-002 SHALL have parameter SAMPLE_POINT, default 7, meaning the tick index (0..15) within a bit at which the line is sampled.
REQ-003 apb_clk_in  input  1  the single clock; all logic on its rising edge.
REQ-004 apb_rstn_in  input  1  reset, synchronous, active-low.
REQ-005 urrst_in  input  1  receiver reset, active-low, synchronous, same effect as apb_rstn_in.
REQ-006 bclk_in  input  1  oversample tick enable, one apb_clk_in cycle wide, 16 per bit time.
REQ-007 rxd_in  input  1  asynchronous serial line, idle high.
REQ-008 loop_in  input  1  1 selects txd_loop_in as the line source instead of rxd_in.
REQ-009 txd_loop_in  input  1  loopback source from the local transmitter.
REQ-010 wls_in  input  2  word length select: 0/1/2/3 -> 5/6/7/8 data bits.
REQ-011 pen_in, eps_in, sp_in  input  1 each  parity enable, even-parity select, stick parity.
REQ-012 rbr_rd_in  input  1  one-cycle pulse: host read of rbr_out.
REQ-013 lsr_rd_in  input  1  one-cycle pulse: host read of line status.
REQ-014 rbr_out  output  8  last received character, right-justified, unused upper bits 0.
REQ-015 dr_out, oe_out, pe_out, fe_out, bi_out  output  1 each  data ready, overrun, parity error, framing error, break.
REQ-016 busy_out  output  1  1 whenever the state is not IDLE.

Function
REQ-017 Line source (mux by loop_in) SHALL pass a 2-flop synchronizer; all decisions use its output.
REQ-018 State machine SHALL have states IDLE, START, DATA, PARITY, STOP, BREAK; a 4-bit tick counter advances only on bclk_in.
REQ-019 IDLE -> START on synchronized line low; tick counter cleared to 0 on entry.
REQ-020 Sample tick = bclk_in high while tick counter == SAMPLE_POINT; the counter wraps 15 -> 0 at each bit boundary.
REQ-021 START: line high at sample tick -> IDLE (false start, no flags); line low -> DATA at the next bit boundary.
REQ-022 DATA: SHALL shift wls_in+5 bits, LSB first, one per sample tick; then PARITY if pen_in=1, else STOP.
REQ-023 Parity expected value: sp_in=0 -> XOR of data bits, inverted when eps_in=0 (odd parity); sp_in=1 -> constant bit equal to ~eps_in.
REQ-024 STOP: only the first stop bit SHALL be checked; line low at its sample tick -> framing error.
REQ-025 Break SHALL be detected when data, parity (if enabled) and stop samples are all 0: set bi and fe, load rbr_out=0x00, then enter BREAK.
REQ-026 BREAK -> IDLE only after the synchronized line is sampled high on a bclk_in tick.
REQ-027 Non-break frames: STOP -> IDLE at the same edge that samples the stop bit, so the next start edge can be detected mid-stop-bit.
REQ-028 Character load SHALL occur at the stop-bit sample edge: rbr_out, dr_out=1, pe/fe/bi per frame; outputs visible the following cycle.
REQ-029 Load with dr_out=1 and no rbr_rd_in in the same cycle SHALL set oe_out=1; rbr_out is overwritten by the new character.
REQ-030 rbr_rd_in SHALL clear dr_out; if a load occurs in the same cycle, dr_out stays 1 and oe_out is not set.
REQ-031 oe/pe/fe/bi SHALL be sticky until lsr_rd_in; if a set and an lsr_rd_in occur in the same cycle, the set wins.
REQ-032 Changing wls_in, pen_in, eps_in, sp_in or loop_in mid-frame is undefined; the current frame may be corrupted, but the FSM SHALL return to IDLE within one frame time.

Reset
REQ-033 apb_rstn_in=0 or urrst_in=0 at a clock edge SHALL force: state IDLE, counters 0, synchronizer flops 1, rbr_out=0x00, dr/oe/pe/fe/bi/busy=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial character with no flag change other than clearing; reception restarts only on a new falling edge after release.

Verification
REQ-035 8N1, line sends 0xA5 at 16 ticks/bit -> rbr_out=0xA5, dr_out=1, all error flags 0; rbr_rd_in -> dr_out=0.
REQ-036 7E1 (wls=2, pen=1, eps=1), 0x41 sent with a wrong parity bit -> rbr_out=0x41, pe_out=1; lsr_rd_in -> pe_out=0.
REQ-037 Line held low for 12 bit times -> bi_out=1, fe_out=1, rbr_out=0x00, busy_out stays 1 until the line goes high, then 0.
REQ-038 Two 8N1 chars 0x11 then 0x22 with no read -> rbr_out=0x22, oe_out=1; rbr_rd_in coincident with the second load -> oe_out=0, dr_out=1.
REQ-039 Low glitch of 4 ticks on an idle line -> no dr_out, busy_out returns to 0 by tick 8.
REQ-040 loop_in=1, txd_loop_in sends 0x5A while rxd_in held low -> rbr_out=0x5A with no break; urrst_in=0 mid-frame -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/uart_rx_if.sv
// UART receiver host-side bundle: oversample tick, line inputs,
// frame format controls, host read strobes and receiver status.
interface uart_rx_if;
    logic       bclk_in;
    logic       rxd_in;
    logic       loop_in;
    logic       txd_loop_in;
    logic [1:0] wls_in;
    logic       pen_in;
    logic       eps_in;
    logic       sp_in;
    logic       rbr_rd_in;
    logic       lsr_rd_in;
    logic [7:0] rbr_out;
    logic       dr_out;
    logic       oe_out;
    logic       pe_out;
    logic       fe_out;
    logic       bi_out;
    logic       busy_out;

    modport master (
        output bclk_in, rxd_in, loop_in, txd_loop_in,
        output wls_in, pen_in, eps_in, sp_in,
        output rbr_rd_in, lsr_rd_in,
        input  rbr_out, dr_out, oe_out, pe_out,
        input  fe_out, bi_out, busy_out
    );

    modport slave (
        input  bclk_in, rxd_in, loop_in, txd_loop_in,
        input  wls_in, pen_in, eps_in, sp_in,
        input  rbr_rd_in, lsr_rd_in,
        output rbr_out, dr_out, oe_out, pe_out,
        output fe_out, bi_out, busy_out
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5..8 data bits, optional parity,
// break detection, sticky line status.
// Ports: apb_clk_in clock, apb_rstn_in / urrst_in sync active-low
// resets, bus = uart_rx_if.slave (line, format, reads, status).
module uart_rx #(
    parameter int OVERSAMPLE   = 16,
    parameter int SAMPLE_POINT = 7
) (
    input  logic     apb_clk_in,
    input  logic     apb_rstn_in,
    input  logic     urrst_in,
    uart_rx_if.slave bus
);
    localparam logic [3:0] LAST_TICK   = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] SAMPLE_TICK = 4'(SAMPLE_POINT);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic [3:0] bit_q;
    logic [7:0] data_q;
    logic       zero_q;
    logic       perr_q;
    logic [7:0] rbr_q;
    logic       dr_q, oe_q, pe_q, fe_q, bi_q;

    logic       rst;
    logic       line_s;
    logic       sample;
    logic       boundary;
    logic [3:0] nbits;
    logic       exp_par;
    logic       load;
    logic       brk;

    assign rst      = !apb_rstn_in || !urrst_in;
    assign line_s   = sync_q[1];
    assign sample   = bus.bclk_in && (cnt_q == SAMPLE_TICK);
    assign boundary = bus.bclk_in && (cnt_q == LAST_TICK);
    assign nbits    = 4'(bus.wls_in) + 4'd5;
    // Unused upper data bits stay 0, so the full XOR is the frame XOR.
    assign exp_par  = bus.sp_in ? ~bus.eps_in
                                : (^data_q) ^ ~bus.eps_in;

    always_ff @(posedge apb_clk_in) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        brk     = 1'b0;
        unique case (state_q)
            IDLE:   if (!line_s) state_d = START;
            START: begin
                if (sample && line_s) state_d = IDLE;
                else if (boundary)    state_d = DATA;
            end
            // >= keeps a mid-frame width change from hanging the FSM.
            DATA:   if (boundary && bit_q >= nbits)
                        state_d = bus.pen_in ? PARITY : STOP;
            PARITY: if (boundary) state_d = STOP;
            STOP: begin
                if (sample) begin
                    load = 1'b1;
                    if (zero_q && !line_s) begin
                        brk     = 1'b1;
                        state_d = BREAK;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BREAK:  if (bus.bclk_in && line_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge apb_clk_in) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            bit_q  <= '0;
            data_q <= '0;
            zero_q <= 1'b1;
            perr_q <= 1'b0;
            rbr_q  <= '0;
            dr_q   <= 1'b0;
            oe_q   <= 1'b0;
            pe_q   <= 1'b0;
            fe_q   <= 1'b0;
            bi_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0],
                       bus.loop_in ? bus.txd_loop_in : bus.rxd_in};

            if (state_q == IDLE)  cnt_q <= '0;
            else if (bus.bclk_in) cnt_q <= cnt_q + 4'd1;

            if (state_q == IDLE) begin
                bit_q  <= '0;
                data_q <= '0;
                zero_q <= 1'b1;
                perr_q <= 1'b0;
            end

            if (state_q == DATA && sample) begin
                if (bit_q < 4'd8) data_q[bit_q[2:0]] <= line_s;
                bit_q  <= bit_q + 4'd1;
                zero_q <= zero_q & !line_s;
            end

            if (state_q == PARITY && sample) begin
                perr_q <= line_s != exp_par;
                zero_q <= zero_q & !line_s;
            end

            if (load) rbr_q <= brk ? 8'h00 : data_q;

            if (load)               dr_q <= 1'b1;
            else if (bus.rbr_rd_in) dr_q <= 1'b0;

            // A set in the same cycle as an LSR read wins.
            if (load && dr_q && !bus.rbr_rd_in) oe_q <= 1'b1;
            else if (bus.lsr_rd_in)             oe_q <= 1'b0;

            if (load && !brk && perr_q) pe_q <= 1'b1;
            else if (bus.lsr_rd_in)     pe_q <= 1'b0;

            if (load && !line_s)    fe_q <= 1'b1;
            else if (bus.lsr_rd_in) fe_q <= 1'b0;

            if (brk)                bi_q <= 1'b1;
            else if (bus.lsr_rd_in) bi_q <= 1'b0;
        end
    end

    assign bus.rbr_out  = rbr_q;
    assign bus.dr_out   = dr_q;
    assign bus.oe_out   = oe_q;
    assign bus.pe_out   = pe_q;
    assign bus.fe_out   = fe_q;
    assign bus.bi_out   = bi_q;
    assign bus.busy_out = state_q != IDLE;
endmodule
